hazard_controller: RTL

Pipeline sequencing unit for the 5-stage datapath driven by the opcode decoder.
- Detects load-use hazards and holds PC and IF/ID while bubbling ID/EX.
- Flushes younger stages on control transfers resolved in MEM.
- Freezes the pipeline while data memory is busy, and runs a clean boot flush after reset.
- Keeps saturating stall and flush counters for performance measurement.

---
 rtl/hazard_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline sequencing unit: boot flush, load-use bubbling, MEM redirect flushes,
// memory-busy freeze, and saturating stall/flush performance counters.
module hazard_controller #(
  parameter int REG_BITS    = 6,
  parameter int BOOT_CYCLES = 3,
  parameter int CNT_BITS    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          IDOpcode,
  input  logic [REG_BITS-1:0] IDRs,
  input  logic [REG_BITS-1:0] IDRt,
  input  logic                EXMemRead,
  input  logic [REG_BITS-1:0] EXRd,
  input  logic                MEMRedirect,
  input  logic                MemBusy,
  output logic                PCWrite,
  output logic                IFIDWrite,
  output logic                IDEXBubble,
  output logic                IFIDFlush,
  output logic                IDEXFlush,
  output logic                EXMEMFlush,
  output logic [CNT_BITS-1:0] StallCount,
  output logic [CNT_BITS-1:0] FlushCount,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          boot_cnt_q, boot_cnt_d;
  logic [CNT_BITS-1:0] stall_q, stall_d;
  logic [CNT_BITS-1:0] flush_q, flush_d;

  logic uses_rs, uses_rt, load_use;
  logic stall_inc, flush_inc;

  assign uses_rs  = !((IDOpcode == 4'b0000) || (IDOpcode == 4'b1111));
  assign uses_rt  = IDOpcode inside {4'b0011, 4'b0100, 4'b0110, 4'b0111};
  assign load_use = EXMemRead && ((uses_rs && (IDRs == EXRd)) ||
                                  (uses_rt && (IDRt == EXRd)));

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    PCWrite    = 1'b0;
    IFIDWrite  = 1'b0;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    case (state_q)
      ST_RUN, ST_FREEZE: begin
        if ((state_q == ST_FREEZE) && MemBusy) begin
          // Frozen: everything holds, redirects wait until memory is ready.
          stall_inc = 1'b1;
        end else begin
          state_d = ST_RUN;
          if (MEMRedirect) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
            flush_inc  = 1'b1;
          end else if (MemBusy) begin
            state_d   = ST_FREEZE;
            stall_inc = 1'b1;
          end else if (load_use) begin
            IDEXBubble = 1'b1;
            stall_inc  = 1'b1;
          end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
          end
        end
      end
      default: begin
        // Boot (and any illegal encoding) flushes everything until the count expires.
        IDEXBubble = 1'b1;
        IFIDFlush  = 1'b1;
        IDEXFlush  = 1'b1;
        EXMEMFlush = 1'b1;
        if (state_q != ST_BOOT) begin
          state_d    = ST_BOOT;
          boot_cnt_d = BOOT_INIT;
        end else if (boot_cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != {CNT_BITS{1'b1}})) stall_d = stall_q + CNT_BITS'(1);
    if (flush_inc && (flush_q != {CNT_BITS{1'b1}})) flush_d = flush_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_INIT;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign StallCount = stall_q;
  assign FlushCount = flush_q;
  assign dbg_state  = state_q;

endmodule
